cnt_reg_arb: RTL and testbench



---
 rtl/cnt_reg_arb.sv | 137 +++++++++++++
 tb/tb_cnt_reg_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_reg_arb.sv
// rtl/cnt_reg_arb.sv - timer counter, compare and interrupt registers with per-cycle counter arbitration
// Counter priority: timer-disable clear, then software write, then cnt_en tick.
module cnt_reg_arb #(
  parameter int CNT_W  = 64,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  timer_en,
  input  logic                  cnt_en,
  input  logic                  halt_req,
  input  logic                  dbg_mode,
  input  logic                  wr_en,
  input  logic [2:0]            wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [2:0]            rd_sel,
  output logic [DATA_W-1:0]     rd_data,
  output logic [CNT_W-1:0]      cnt,
  output logic                  halt_ack,
  output logic                  int_st,
  output logic                  tim_int
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] SEL_TDR0  = 3'd0;
  localparam logic [2:0] SEL_TDR1  = 3'd1;
  localparam logic [2:0] SEL_TCMP0 = 3'd2;
  localparam logic [2:0] SEL_TCMP1 = 3'd3;
  localparam logic [2:0] SEL_TISR  = 3'd4;
  localparam logic [2:0] SEL_TIER  = 3'd5;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             int_st_q, int_st_d;
  logic             int_en_q, int_en_d;
  logic             halt_ack_q;
  logic             timer_en_q;

  logic en_fall;
  logic halted;
  logic match;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign en_fall = timer_en_q & ~timer_en;
  assign halted  = halt_req & dbg_mode;
  assign match   = (cnt_q == cmp_q);

  always_comb begin
    cnt_d = cnt_q;
    if (en_fall) begin
      cnt_d = '0;
    end else if (wr_en && wr_sel == SEL_TDR0) begin
      cnt_d[DATA_W-1:0] = byte_merge(cnt_q[DATA_W-1:0], wr_data, wr_strb);
    end else if (wr_en && wr_sel == SEL_TDR1) begin
      cnt_d[CNT_W-1:DATA_W] = byte_merge(cnt_q[CNT_W-1:DATA_W], wr_data, wr_strb);
    end else if (cnt_en && !halted) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_en && wr_sel == SEL_TCMP0) begin
      cmp_d[DATA_W-1:0] = byte_merge(cmp_q[DATA_W-1:0], wr_data, wr_strb);
    end else if (wr_en && wr_sel == SEL_TCMP1) begin
      cmp_d[CNT_W-1:DATA_W] = byte_merge(cmp_q[CNT_W-1:DATA_W], wr_data, wr_strb);
    end
  end

  // A live match wins over a same-cycle W1C so a held match cannot be cleared.
  always_comb begin
    int_st_d = int_st_q;
    if (match) begin
      int_st_d = 1'b1;
    end else if (wr_en && wr_sel == SEL_TISR && wr_strb[0] && wr_data[0]) begin
      int_st_d = 1'b0;
    end
  end

  always_comb begin
    int_en_d = int_en_q;
    if (wr_en && wr_sel == SEL_TIER && wr_strb[0]) begin
      int_en_d = wr_data[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cmp_q      <= '1;
      int_st_q   <= 1'b0;
      int_en_q   <= 1'b0;
      halt_ack_q <= 1'b0;
      timer_en_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      int_st_q   <= int_st_d;
      int_en_q   <= int_en_d;
      halt_ack_q <= halted;
      timer_en_q <= timer_en;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_TDR0:  rd_data = cnt_q[DATA_W-1:0];
      SEL_TDR1:  rd_data = cnt_q[CNT_W-1:DATA_W];
      SEL_TCMP0: rd_data = cmp_q[DATA_W-1:0];
      SEL_TCMP1: rd_data = cmp_q[CNT_W-1:DATA_W];
      SEL_TISR:  rd_data = {{(DATA_W-1){1'b0}}, int_st_q};
      SEL_TIER:  rd_data = {{(DATA_W-1){1'b0}}, int_en_q};
      default:   rd_data = '0;
    endcase
  end

  assign cnt      = cnt_q;
  assign halt_ack = halt_ack_q;
  assign int_st   = int_st_q;
  assign tim_int  = int_st_q & int_en_q;

endmodule

// File: tb/tb_cnt_reg_arb.sv
// tb/tb_cnt_reg_arb.sv - directed-vector bench for cnt_reg_arb
module tb_cnt_reg_arb;

  logic        clk;
  logic        rst;
  logic        timer_en;
  logic        cnt_en;
  logic        halt_req;
  logic        dbg_mode;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [63:0] cnt;
  logic        halt_ack;
  logic        int_st;
  logic        tim_int;

  int vectors;
  int miscompares;
  logic [31:0] rv;

  cnt_reg_arb #(.CNT_W(64), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .cnt_en(cnt_en),
    .halt_req(halt_req), .dbg_mode(dbg_mode), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_strb(wr_strb), .rd_sel(rd_sel), .rd_data(rd_data),
    .cnt(cnt), .halt_ack(halt_ack), .int_st(int_st), .tim_int(tim_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_sel = sel; wr_data = d; wr_strb = s;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, output logic [31:0] d);
    rd_sel = sel;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; timer_en = 1'b1; cnt_en = 1'b0; halt_req = 1'b0; dbg_mode = 1'b0;
    wr_en = 1'b0; wr_sel = 3'd0; wr_data = '0; wr_strb = '0; rd_sel = 3'd0;
    step(); step();
    vectors++;
    if (cnt !== 64'd0) begin miscompares++; $display("FAIL reset_cnt: got %h exp %h", cnt, 64'd0); end
    vectors++;
    if ({halt_ack, int_st, tim_int} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b exp 000", {halt_ack, int_st, tim_int});
    end
    rd(3'd3, rv);
    vectors++;
    if (rv !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_cmp_hi: got %h exp ffffffff", rv); end
    rd(3'd5, rv);
    vectors++;
    if (rv !== 32'd0) begin miscompares++; $display("FAIL reset_tier: got %h exp 0", rv); end
    rst = 1'b0;
  endtask

  task automatic test_count();
    cnt_en = 1'b1;
    repeat (10) step();
    cnt_en = 1'b0;
    vectors++;
    if (cnt !== 64'd10) begin miscompares++; $display("FAIL count10: got %h exp %h", cnt, 64'd10); end
    rd(3'd0, rv);
    vectors++;
    if (rv !== 32'h0000_000A) begin miscompares++; $display("FAIL count10_rd: got %h exp 0000000a", rv); end
    vectors++;
    if (int_st !== 1'b0) begin miscompares++; $display("FAIL count10_int: got %b exp 0", int_st); end
  endtask

  task automatic test_write_carry();
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'h0000_0001, 4'hF);
    vectors++;
    if (cnt !== 64'h0000_0001_FFFF_FFFF) begin miscompares++; $display("FAIL tdr_write: got %h exp 00000001ffffffff", cnt); end
    cnt_en = 1'b1; step(); cnt_en = 1'b0;
    vectors++;
    if (cnt !== 64'h0000_0002_0000_0000) begin miscompares++; $display("FAIL carry: got %h exp 0000000200000000", cnt); end
    wr(3'd0, 32'h0000_0055, 4'b0001);
    vectors++;
    if (cnt !== 64'h0000_0002_0000_0055) begin miscompares++; $display("FAIL strb_merge: got %h exp 0000000200000055", cnt); end
    wr(3'd1, 32'hAABB_CCDD, 4'b0100);
    vectors++;
    if (cnt !== 64'h00BB_0002_0000_0055) begin miscompares++; $display("FAIL strb_merge_hi: got %h exp 00bb000200000055", cnt); end
    wr(3'd6, 32'h1234_5678, 4'hF);
    vectors++;
    if (cnt !== 64'h00BB_0002_0000_0055) begin miscompares++; $display("FAIL unmapped_wr: got %h exp 00bb000200000055", cnt); end
  endtask

  task automatic test_interrupt();
    wr(3'd2, 32'd5, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd5, 32'd1, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'd0, 4'hF);
    cnt_en = 1'b1;
    repeat (5) step();
    cnt_en = 1'b0;
    vectors++;
    if ({cnt[3:0], int_st} !== {4'd5, 1'b0}) begin
      miscompares++; $display("FAIL int_not_yet: got cnt=%h int_st=%b exp cnt=5 int_st=0", cnt, int_st);
    end
    step();
    vectors++;
    if ({int_st, tim_int} !== 2'b11) begin miscompares++; $display("FAIL int_rise: got %b exp 11", {int_st, tim_int}); end
    wr(3'd4, 32'd1, 4'hF);
    vectors++;
    if (int_st !== 1'b1) begin miscompares++; $display("FAIL int_set_prio: got %b exp 1", int_st); end
    cnt_en = 1'b1; step(); cnt_en = 1'b0;
    wr(3'd5, 32'd0, 4'hF);
    vectors++;
    if ({int_st, tim_int} !== 2'b10) begin miscompares++; $display("FAIL int_mask: got %b exp 10", {int_st, tim_int}); end
    wr(3'd4, 32'd0, 4'hF);
    vectors++;
    if (int_st !== 1'b1) begin miscompares++; $display("FAIL w1c_zero: got %b exp 1", int_st); end
    wr(3'd4, 32'd1, 4'hF);
    rd(3'd4, rv);
    vectors++;
    if (rv !== 32'd0) begin miscompares++; $display("FAIL w1c_clear: got %h exp 0", rv); end
  endtask

  task automatic test_back_to_back();
    cnt_en = 1'b1;
    wr(3'd0, 32'h0000_0100, 4'hF);
    cnt_en = 1'b0;
    vectors++;
    if (cnt !== 64'h100) begin miscompares++; $display("FAIL wr_over_tick: got %h exp 100", cnt); end
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    cnt_en = 1'b1; step(); cnt_en = 1'b0;
    vectors++;
    if (cnt !== 64'd0) begin miscompares++; $display("FAIL wrap: got %h exp 0", cnt); end
  endtask

  task automatic test_halt();
    dbg_mode = 1'b1; cnt_en = 1'b1;
    step();
    halt_req = 1'b1;
    #1;
    vectors++;
    if (halt_ack !== 1'b0) begin miscompares++; $display("FAIL halt_ack_early: got %b exp 0", halt_ack); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({cnt, halt_ack} !== {64'd1, 1'b1}) begin
        miscompares++; $display("FAIL halt_freeze_%0d: got cnt=%h ack=%b exp cnt=1 ack=1", i, cnt, halt_ack);
      end
    end
    halt_req = 1'b0;
    step();
    vectors++;
    if ({cnt, halt_ack} !== {64'd2, 1'b0}) begin
      miscompares++; $display("FAIL halt_release: got cnt=%h ack=%b exp cnt=2 ack=0", cnt, halt_ack);
    end
    dbg_mode = 1'b0; halt_req = 1'b1;
    step(); step();
    vectors++;
    if ({cnt, halt_ack} !== {64'd4, 1'b0}) begin
      miscompares++; $display("FAIL halt_no_dbg: got cnt=%h ack=%b exp cnt=4 ack=0", cnt, halt_ack);
    end
    halt_req = 1'b0; cnt_en = 1'b0;
  endtask

  task automatic test_disable();
    wr(3'd5, 32'd1, 4'hF);
    wr(3'd0, 32'h0000_1234, 4'hF);
    vectors++;
    if (cnt !== 64'h1234) begin miscompares++; $display("FAIL dis_setup: got %h exp 1234", cnt); end
    timer_en = 1'b0;
    wr(3'd1, 32'h0000_ABCD, 4'hF);
    vectors++;
    if (cnt !== 64'd0) begin miscompares++; $display("FAIL dis_clear: got %h exp 0", cnt); end
    rd(3'd2, rv);
    vectors++;
    if (rv !== 32'd5) begin miscompares++; $display("FAIL dis_cmp: got %h exp 5", rv); end
    rd(3'd5, rv);
    vectors++;
    if (rv !== 32'd1) begin miscompares++; $display("FAIL dis_tier: got %h exp 1", rv); end
    timer_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    cnt_en = 1'b1; step(); step();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({cnt, int_st, halt_ack} !== {64'd0, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL rst_async: got cnt=%h int_st=%b ack=%b exp 0", cnt, int_st, halt_ack);
    end
    rd(3'd2, rv);
    vectors++;
    if (rv !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL rst_cmp: got %h exp ffffffff", rv); end
    step();
    rst = 1'b0;
    step();
    cnt_en = 1'b0;
    vectors++;
    if (cnt !== 64'd1) begin miscompares++; $display("FAIL rst_first_inc: got %h exp 1", cnt); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_count();
    test_write_carry();
    test_interrupt();
    test_back_to_back();
    test_halt();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
